multiplier_booth: RTL and testbench
===================================

MULTIPLIER_BOOTH -- requirements
Module: multiplier_booth

Interface
- REQ-001 Parameters: none; operand width is fixed at 32 bits.
- REQ-002 clock  input  1  single clock; all state updates on the rising edge.
- REQ-003 reset  input  1  reset is synchronous and active-high.
- REQ-004 data_operandA  input  32  multiplicand, two's complement; sampled only on a start edge.
- REQ-005 data_operandB  input  32  multiplier, two's complement; sampled only on a start edge.
- REQ-006 ctrl_MULT  input  1  start request; a rising clock edge with ctrl_MULT=1 is a start edge.
- REQ-007 data_result  output  32  low 32 bits of the signed 64-bit product.
- REQ-008 data_exception  output  1  overflow flag: product not representable in signed 32 bits.
- REQ-009 data_resultRDY  output  1  one-cycle pulse marking the result valid.

Function
- REQ-010 The block SHALL compute the signed 32x32 product using radix-4 modified Booth recoding over exactly 16 iterations.
- REQ-011 State machine states SHALL be IDLE, BUSY and DONE.
- REQ-012 On a start edge the block SHALL capture data_operandA into a multiplicand register.
- REQ-013 On the same start edge it SHALL load the product register as {34'b0, data_operandB, 1'b0}.
- REQ-014 On the same start edge it SHALL clear the iteration counter and enter BUSY, regardless of the current state.
- REQ-015 After capture, the operand inputs SHALL NOT affect the computation.
- REQ-016 Each BUSY edge SHALL recode product bits [2:0] into a digit in {0, ±M, ±2M}.
- REQ-017 The selected digit SHALL be added into the 34-bit upper accumulator with sign extension.
- REQ-018 The product register SHALL then be shifted arithmetic-right by 2.
- REQ-019 The iteration counter SHALL increment on each BUSY edge.
- REQ-020 The 16th BUSY edge (start edge E0 + 16) SHALL move the state to DONE.
- REQ-021 data_resultRDY SHALL be 1 only while in DONE, for exactly one cycle (between E16 and E17).
- REQ-022 DONE SHALL go to IDLE on the next edge unless that edge is a start edge.
- REQ-023 data_result SHALL equal product bits [32:1] (low 32 bits of the product) from E16 until the next start edge or reset; it is unspecified while BUSY.
- REQ-024 data_exception SHALL be 1 when product bits [63:31] are not all equal; it is valid under the same window as data_result.
- REQ-025 A start edge while BUSY SHALL abort the current operation and restart it; no RDY pulse is produced for the aborted operation.
- REQ-026 A start edge while in DONE SHALL restart the operation, and RDY SHALL be 0 in the following cycle.
- REQ-027 If ctrl_MULT is held high, every edge SHALL be a start edge, and RDY SHALL never assert.
- REQ-028 The corner case -2^31 * -2^31 SHALL give data_result=0x00000000 and data_exception=1 (no intermediate wrap; the 34-bit accumulator covers ±2M).

Reset
- REQ-029 Reset SHALL take priority over ctrl_MULT on the same edge.
- REQ-030 Reset SHALL force state=IDLE, counter=0 and the product and multiplicand registers to 0.
- REQ-031 Reset SHALL force data_result=0, data_exception=0 and data_resultRDY=0.
- REQ-032 Reset while BUSY SHALL discard the operation, and no RDY pulse SHALL follow.
- REQ-033 The next start edge after reset SHALL behave as a normal start.

Structure
- REQ-034 The shared package multdiv_pkg SHALL hold the state enum (IDLE/BUSY/DONE).
- REQ-035 multdiv_pkg SHALL hold the constant MULT_ITERS=16 and the Booth digit encoding typedef.
- REQ-036 One sub-module, booth_recoder, SHALL map 3 bits plus the multiplicand to a 34-bit signed addend.
- REQ-037 The existing cla adder MAY be used for the 34-bit accumulate step.

Verification
- REQ-038 A=3, B=4, start, no further input -> at E16, RDY=1, data_result=0x0000000C, data_exception=0; at E17, RDY=0.
- REQ-039 A=-7, B=6 -> data_result=0xFFFFFFD6, data_exception=0.
- REQ-040 A=0x7FFFFFFF, B=2 -> data_result=0xFFFFFFFE, data_exception=1.
- REQ-041 A=0x80000000, B=0xFFFFFFFF -> data_result=0x80000000, data_exception=1.
- REQ-042 Start A=5, B=5, then at E5 start again with A=9, B=-1 -> exactly one RDY pulse, 16 edges after the second start, with data_result=0xFFFFFFF7.
- REQ-043 Start, then reset at E8 -> RDY stays 0 for 20 cycles, and data_result=0 with data_exception=0.

Source files
------------

// File: rtl/multdiv_pkg.sv
// Shared types and constants for the multiply/divide datapath family:
// controller states, Booth digit encoding and the overflow helper.
package multdiv_pkg;

  localparam int OP_W       = 32;
  localparam int ACC_W      = 34;
  localparam int PROD_W     = 67;
  localparam int MULT_ITERS = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mult_state_e;

  typedef enum logic [2:0] {
    DIG_ZERO = 3'd0,
    DIG_POS1 = 3'd1,
    DIG_POS2 = 3'd2,
    DIG_NEG1 = 3'd3,
    DIG_NEG2 = 3'd4
  } booth_digit_e;

  function automatic booth_digit_e booth_encode(input logic [2:0] sel);
    booth_digit_e digit;
    case (sel)
      3'b000:         digit = DIG_ZERO;
      3'b001, 3'b010: digit = DIG_POS1;
      3'b011:         digit = DIG_POS2;
      3'b100:         digit = DIG_NEG2;
      3'b101, 3'b110: digit = DIG_NEG1;
      3'b111:         digit = DIG_ZERO;
      default:        digit = DIG_ZERO;
    endcase
    return digit;
  endfunction

  // hi carries product bits [63:31]; the product fits in 32 signed bits only if they agree
  function automatic logic prod_overflow(input logic [32:0] hi);
    return !((&hi) || !(|hi));
  endfunction

endpackage

// File: rtl/multiplier_booth_if.sv
// Operand/result bundle between a requester and the Booth multiplier.
interface multiplier_booth_if;

  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic        ctrl_MULT;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;

  modport master (
    output data_operandA, data_operandB, ctrl_MULT,
    input  data_result, data_exception, data_resultRDY
  );

  modport slave (
    input  data_operandA, data_operandB, ctrl_MULT,
    output data_result, data_exception, data_resultRDY
  );

endinterface

// File: rtl/booth_recoder.sv
// Radix-4 Booth recoder: three overlapping multiplier bits select a
// 34-bit signed addend from {0, +-M, +-2M}.
module booth_recoder
  import multdiv_pkg::*;
(
  input  logic [2:0]  sel,
  input  logic [31:0] mcand,
  output logic [33:0] addend
);

  logic [33:0]  m1_s;
  logic [33:0]  m2_s;
  booth_digit_e digit_s;

  assign m1_s = {{2{mcand[31]}}, mcand};
  assign m2_s = {mcand[31], mcand, 1'b0};

  // Digit to addend; 34 bits leave headroom for -2 * (-2^31).
  always_comb begin
    digit_s = booth_encode(sel);
    addend  = 34'd0;
    case (digit_s)
      DIG_ZERO: addend = 34'd0;
      DIG_POS1: addend = m1_s;
      DIG_POS2: addend = m2_s;
      DIG_NEG1: addend = 34'd0 - m1_s;
      DIG_NEG2: addend = 34'd0 - m2_s;
      default:  addend = 34'd0;
    endcase
  end

endmodule

// File: rtl/cla.sv
// Carry-lookahead adder: 4-bit groups, every carry in a group derived
// directly from the group's incoming carry.
module cla #(
  parameter int WIDTH = 34
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum
);

  localparam int GW = 4;

  logic [WIDTH-1:0] g_s;
  logic [WIDTH-1:0] p_s;
  logic [WIDTH-1:0] c_s;
  logic             la_s;

  assign g_s = a & b;
  assign p_s = a ^ b;

  // Expand the generate/propagate chain from each group base carry.
  always_comb begin
    c_s    = {WIDTH{1'b0}};
    la_s   = 1'b0;
    c_s[0] = cin;
    for (int base = 0; base < WIDTH; base += GW) begin
      for (int k = 1; (k <= GW) && (base + k < WIDTH); k++) begin
        la_s = c_s[base];
        for (int j = base; j < base + k; j++) begin
          la_s = g_s[j] | (p_s[j] & la_s);
        end
        c_s[base + k] = la_s;
      end
    end
  end

  assign sum = p_s ^ c_s;

endmodule

// File: rtl/multiplier_booth_chk.sv
// Structural invariants of the Booth multiplier controller.
module multiplier_booth_chk
  import multdiv_pkg::*;
(
  input logic        clock,
  input logic        reset,
  input mult_state_e state,
  input logic [4:0]  cnt,
  input logic        rdy
);

  a_rdy_only_done: assert property (@(posedge clock) disable iff (reset)
    rdy == (state == DONE));

  a_cnt_bounded: assert property (@(posedge clock) disable iff (reset)
    cnt <= 5'(MULT_ITERS));

  a_state_legal: assert property (@(posedge clock) disable iff (reset)
    (state == IDLE) || (state == BUSY) || (state == DONE));

endmodule

// File: rtl/multiplier_booth.sv
// Signed 32x32 multiplier, radix-4 Booth, 16 iterations; reports the low
// word of the product plus a 32-bit signed overflow flag.
module multiplier_booth
  import multdiv_pkg::*;
(
  input logic               clock,
  input logic               reset,
  multiplier_booth_if.slave bus
);

  mult_state_e       state_r;
  mult_state_e       state_s;
  logic [4:0]        cnt_r;
  logic [4:0]        cnt_s;
  logic [OP_W-1:0]   mcand_r;
  logic [OP_W-1:0]   mcand_s;
  logic [PROD_W-1:0] prod_r;
  logic [PROD_W-1:0] prod_s;
  logic [ACC_W-1:0]  addend_s;
  logic [ACC_W-1:0]  acc_s;
  logic [PROD_W-1:0] sum_s;
  logic [31:0]       result_r;
  logic              exception_r;
  logic              rdy_r;

  booth_recoder u_recoder (
    .sel    (prod_r[2:0]),
    .mcand  (mcand_r),
    .addend (addend_s)
  );

  cla #(.WIDTH(ACC_W)) u_acc (
    .a   (prod_r[PROD_W-1:PROD_W-ACC_W]),
    .b   (addend_s),
    .cin (1'b0),
    .sum (acc_s)
  );

  assign sum_s = {acc_s, prod_r[PROD_W-ACC_W-1:0]};

  // Next state and datapath; a start request overrides whatever is running.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    mcand_s = mcand_r;
    prod_s  = prod_r;
    if (bus.ctrl_MULT) begin
      state_s = BUSY;
      cnt_s   = 5'd0;
      mcand_s = bus.data_operandA;
      prod_s  = {34'd0, bus.data_operandB, 1'b0};
    end else begin
      case (state_r)
        IDLE: state_s = IDLE;
        BUSY: begin
          prod_s = $signed(sum_s) >>> 2'd2;
          cnt_s  = cnt_r + 5'd1;
          if (cnt_r == 5'(MULT_ITERS - 1)) begin
            state_s = DONE;
          end else begin
            state_s = BUSY;
          end
        end
        DONE:    state_s = IDLE;
        default: state_s = IDLE;
      endcase
    end
  end

  // Controller and datapath registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= 5'd0;
      mcand_r <= 32'd0;
      prod_r  <= {PROD_W{1'b0}};
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      mcand_r <= mcand_s;
      prod_r  <= prod_s;
    end
  end

  // Output registers track the next product so they line up with DONE.
  always_ff @(posedge clock) begin
    if (reset) begin
      result_r    <= 32'd0;
      exception_r <= 1'b0;
      rdy_r       <= 1'b0;
    end else begin
      result_r    <= prod_s[32:1];
      exception_r <= prod_overflow(prod_s[64:32]);
      rdy_r       <= (state_s == DONE);
    end
  end

  assign bus.data_result    = result_r;
  assign bus.data_exception = exception_r;
  assign bus.data_resultRDY = rdy_r;

  multiplier_booth_chk u_chk (
    .clock (clock),
    .reset (reset),
    .state (state_r),
    .cnt   (cnt_r),
    .rdy   (rdy_r)
  );

endmodule

// File: tb/tb_multiplier_booth.sv
// Scoreboard bench for multiplier_booth: expected products from 64-bit
// integer arithmetic, compared whenever the DUT raises its ready pulse.
module tb_multiplier_booth;

  logic        clock = 1'b0;
  logic        reset;
  int          total_cnt = 0;
  int          pass_cnt  = 0;
  logic [32:0] exp_q[$];
  logic [32:0] mon_exp;
  logic [31:0] ha;
  logic [31:0] hb;
  logic [31:0] ra;
  logic [31:0] rb;
  logic [31:0] dir_a[10] = '{32'd3, 32'hFFFFFFF9, 32'h7FFFFFFF, 32'h80000000, 32'h80000000,
                             32'd0, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h00010000};
  logic [31:0] dir_b[10] = '{32'd4, 32'd6, 32'd2, 32'hFFFFFFFF, 32'h80000000,
                             32'hDEADBEEF, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'd1, 32'h00008000};

  multiplier_booth_if bus();

  multiplier_booth dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b);
    longint p;
    logic   ovf;
    p   = longint'($signed(a)) * longint'($signed(b));
    ovf = (p > 64'sd2147483647) || (p < -64'sd2147483648);
    return {ovf, p[31:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total_cnt++;
    if (act === expv) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, expv, $time);
  endtask

  always @(negedge clock) begin
    if (bus.data_resultRDY === 1'b1) begin
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_rdy: got RDY=1 expected RDY=0 at %0t", $time);
      end else begin
        mon_exp = exp_q.pop_front();
        check("result", bus.data_result, mon_exp[31:0]);
        check("exception", {31'd0, bus.data_exception}, {31'd0, mon_exp[32]});
      end
    end
  end

  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input bit expect_done);
    @(negedge clock);
    bus.data_operandA = a;
    bus.data_operandB = b;
    bus.ctrl_MULT     = 1'b1;
    @(posedge clock);
    if (expect_done) exp_q.push_back(model(a, b));
    #1;
    bus.ctrl_MULT     = 1'b0;
    bus.data_operandA = $urandom();
    bus.data_operandB = $urandom();
  endtask

  // Entered one time unit after the start edge E0.
  task automatic wait_result(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] expv;
    expv = model(a, b);
    repeat (15) @(posedge clock);
    #1 check("rdy_before_e16", {31'd0, bus.data_resultRDY}, 32'd0);
    @(posedge clock);
    #1 check("rdy_at_e16", {31'd0, bus.data_resultRDY}, 32'd1);
    @(posedge clock);
    #1 check("rdy_at_e17", {31'd0, bus.data_resultRDY}, 32'd0);
    check("result_hold", bus.data_result, expv[31:0]);
    check("exception_hold", {31'd0, bus.data_exception}, {31'd0, expv[32]});
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b);
    start_op(a, b, 1'b1);
    wait_result(a, b);
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_result"}, bus.data_result, 32'd0);
    check({tag, "_exception"}, {31'd0, bus.data_exception}, 32'd0);
    check({tag, "_rdy"}, {31'd0, bus.data_resultRDY}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset             = 1'b1;
    bus.ctrl_MULT     = 1'b0;
    bus.data_operandA = 32'd0;
    bus.data_operandB = 32'd0;
    repeat (3) @(posedge clock);
    #1 check_idle_zero("reset");
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) run_op(dir_a[i], dir_b[i]);
    for (int i = 0; i < 12; i++) begin
      ra = $urandom();
      rb = (i % 3 == 0) ? 32'($signed($urandom_range(0, 511)) - 256) : $urandom();
      run_op(ra, rb);
    end

    // Restart while busy: only the second operation completes.
    start_op(32'd5, 32'd5, 1'b0);
    repeat (4) @(posedge clock);
    start_op(32'd9, 32'hFFFFFFFF, 1'b1);
    wait_result(32'd9, 32'hFFFFFFFF);

    // Restart on the edge leaving DONE.
    ra = $urandom();
    rb = $urandom();
    start_op(ra, rb, 1'b1);
    repeat (16) @(posedge clock);
    #1 check("rdy_done_before_restart", {31'd0, bus.data_resultRDY}, 32'd1);
    ra = $urandom();
    rb = $urandom();
    start_op(ra, rb, 1'b1);
    check("rdy_after_done_restart", {31'd0, bus.data_resultRDY}, 32'd0);
    wait_result(ra, rb);

    // Start held high for many edges: no ready until it drops.
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      ha = $urandom();
      hb = $urandom();
      bus.data_operandA = ha;
      bus.data_operandB = hb;
      bus.ctrl_MULT     = 1'b1;
      @(posedge clock);
    end
    exp_q.push_back(model(ha, hb));
    #1 bus.ctrl_MULT = 1'b0;
    wait_result(ha, hb);

    // Reset in the middle of an operation.
    start_op(32'h00001234, 32'h00005678, 1'b0);
    repeat (7) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    repeat (20) @(posedge clock);
    #1 check_idle_zero("mid_reset");

    // Reset beats a simultaneous start request.
    @(negedge clock);
    reset             = 1'b1;
    bus.ctrl_MULT     = 1'b1;
    bus.data_operandA = 32'd7;
    bus.data_operandB = 32'd7;
    @(posedge clock);
    @(negedge clock);
    reset         = 1'b0;
    bus.ctrl_MULT = 1'b0;
    repeat (20) @(posedge clock);
    #1 check_idle_zero("reset_priority");

    run_op(32'd3, 32'd4);

    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clock);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    @(negedge clock);
    #1;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
